soc_design_fb_flag_in: RTL and testbench

//  Avalon-MM slave input PIO: HPS-side reader of frame-buffer status flags driven from fabric.

---
 rtl/soc_design_pio_pkg.sv | 13 +
 rtl/soc_design_flag_sync.sv | 24 ++
 rtl/soc_design_fb_flag_in.sv | 109 ++++++++++
 tb/tb_soc_design_fb_flag_in.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/soc_design_pio_pkg.sv
// Shared definitions for the lightweight-bridge PIO slaves: register map and edge-type encodings.
package soc_design_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/soc_design_flag_sync.sv
// WIDTH-wide two-flop synchronizer for fabric flag inputs.
// Latency 2 clk; no backpressure (free-running sampler).
module soc_design_flag_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/soc_design_fb_flag_in.sv
// Avalon-MM input PIO for frame-buffer status flags: level read, per-bit edge capture, masked level irq.
// Latency 1 clk in_port->data/edgecap (3 clk with FB_FLAG_IN_SYNC_EN); zero-wait-state slave, never stalls.
module soc_design_fb_flag_in
    import soc_design_pio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] in_s;
    logic [WIDTH-1:0] in_prev;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr;
    logic             wr_en;
    logic             armed;
    logic             unused_wdata;

    // Arming waits until in_prev holds a genuine sample of in_s, so a flag that is
    // already high when reset releases is never mistaken for an edge.
`ifdef FB_FLAG_IN_SYNC_EN
    localparam int ARM_STAGES = 3;

    soc_design_flag_sync #(
        .WIDTH (WIDTH)
    ) u_flag_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (in_s)
    );
`else
    localparam int ARM_STAGES = 1;

    assign in_s = in_port;
`endif

    logic [ARM_STAGES-1:0] armed_sr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_sr <= '0;
        end else begin
            armed_sr <= (armed_sr << 1) | ARM_STAGES'(1);
        end
    end

    assign armed = armed_sr[ARM_STAGES-1];

    always_comb begin
        edge_raw = in_s & ~in_prev;
        case (EDGE_TYPE)
            EDGE_FALL: edge_raw = ~in_s & in_prev;
            EDGE_ANY:  edge_raw = in_s ^ in_prev;
            default:   edge_raw = in_s & ~in_prev;
        endcase
    end

    assign edge_det = armed ? edge_raw : '0;

    assign wr_en = chipselect & ~write_n;
    assign clr   = (wr_en && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_prev  <= '0;
            data_q   <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            in_prev  <= in_s;
            data_q   <= in_s;
            // A new edge in the same cycle as its W1C clear keeps the bit set.
            edge_cap <= edge_det | (edge_cap & ~clr);
            if (wr_en && address == PIO_ADDR_IRQMASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            PIO_ADDR_DATA:    readdata = 32'(data_q);
            PIO_ADDR_DIR:     readdata = '0;
            PIO_ADDR_IRQMASK: readdata = 32'(irq_mask);
            PIO_ADDR_EDGECAP: readdata = 32'(edge_cap);
            default:          readdata = '0;
        endcase
    end

    assign irq = |(edge_cap & irq_mask);

    assign unused_wdata = ^(writedata >> WIDTH);

endmodule

// File: tb/tb_soc_design_fb_flag_in.sv
// Directed bench for the flag input PIO: rising, falling and any-edge instances share one bus and in_port.
module tb_soc_design_fb_flag_in;
    import soc_design_pio_pkg::*;

`ifdef FB_FLAG_IN_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd_r, rd_f, rd_a;
    logic        irq_r, irq_f, irq_a;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    soc_design_fb_flag_in #(.WIDTH(8), .EDGE_TYPE(EDGE_RISE)) dut_r (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_r), .in_port(in_port), .irq(irq_r));

    soc_design_fb_flag_in #(.WIDTH(8), .EDGE_TYPE(EDGE_FALL)) dut_f (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_f), .in_port(in_port), .irq(irq_f));

    soc_design_fb_flag_in #(.WIDTH(8), .EDGE_TYPE(EDGE_ANY)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_port), .irq(irq_a));

    function automatic logic [31:0] rd_of(input int inst);
        case (inst)
            1:       return rd_f;
            2:       return rd_a;
            default: return rd_r;
        endcase
    endfunction

    function automatic logic irq_of(input int inst);
        case (inst)
            1:       return irq_f;
            2:       return irq_a;
            default: return irq_r;
        endcase
    endfunction

    task automatic push(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic pop(output string tag, output logic [31:0] val);
        if (exp_q.size() == 0) begin
            tag = "empty_queue";
            val = 32'hDEAD_BEEF;
        end else begin
            tag = tag_q.pop_front();
            val = exp_q.pop_front();
        end
    endtask

    task automatic chk_rd(input int inst, input logic [1:0] a);
        string       tag;
        logic [31:0] exp, obs;
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        obs = rd_of(inst);
        pop(tag, exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
        chipselect = 1'b0;
    endtask

    task automatic chk_irq(input int inst);
        string       tag;
        logic [31:0] exp;
        logic        obs;
        #1;
        obs = irq_of(inst);
        pop(tag, exp);
        checks++;
        assert ({31'd0, obs} === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp[0]);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic settle();
        repeat (LAT + 1) @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'hFF;
        repeat (3) @(negedge clk);

        // Reset state, flags held high through release
        push("reset_data0", 32'h0);  chk_rd(0, PIO_ADDR_DATA);
        push("reset_irq", 32'h0);    chk_irq(0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        push("t1_data_r", 32'hFF);   chk_rd(0, PIO_ADDR_DATA);
        push("t1_edge_r", 32'h0);    chk_rd(0, PIO_ADDR_EDGECAP);
        push("t1_edge_a", 32'h0);    chk_rd(2, PIO_ADDR_EDGECAP);
        push("t1_dir_r", 32'h0);     chk_rd(0, PIO_ADDR_DIR);
        push("t1_irq_r", 32'h0);     chk_irq(0);

        // Rising capture, masked irq, partial W1C
        @(negedge clk);
        in_port = 8'h00; settle();
        push("t2_fall_f", 32'hFF);   chk_rd(1, PIO_ADDR_EDGECAP);
        @(negedge clk);
        wr(PIO_ADDR_EDGECAP, 32'hFF);
        push("t2_clr_f", 32'h0);     chk_rd(1, PIO_ADDR_EDGECAP);
        @(negedge clk);
        in_port = 8'h05; settle();
        wr(PIO_ADDR_IRQMASK, 32'h04);
        push("t2_edge_r", 32'h05);   chk_rd(0, PIO_ADDR_EDGECAP);
        push("t2_irq_r", 32'h1);     chk_irq(0);
        push("t2_edge_f", 32'h00);   chk_rd(1, PIO_ADDR_EDGECAP);
        push("t2_irq_f", 32'h0);     chk_irq(1);
        push("t2_edge_a", 32'h05);   chk_rd(2, PIO_ADDR_EDGECAP);
        push("t2_mask_r", 32'h04);   chk_rd(0, PIO_ADDR_IRQMASK);
        @(negedge clk);
        wr(PIO_ADDR_EDGECAP, 32'h04);
        push("t2_w1c_r", 32'h01);    chk_rd(0, PIO_ADDR_EDGECAP);
        push("t2_w1c_irq_r", 32'h0); chk_irq(0);
        push("t2_w1c_a", 32'h01);    chk_rd(2, PIO_ADDR_EDGECAP);

        // Edge and W1C on the same cycle: set wins
        @(negedge clk);
        in_port = 8'h04; settle();
        wr(PIO_ADDR_EDGECAP, 32'hFF);
        in_port = 8'h05;
        repeat (LAT - 1) @(negedge clk);
        wr(PIO_ADDR_EDGECAP, 32'h01);
        @(negedge clk);
        push("t3_setwins_r", 32'h01); chk_rd(0, PIO_ADDR_EDGECAP);
        push("t3_setwins_a", 32'h01); chk_rd(2, PIO_ADDR_EDGECAP);
        push("t3_clr_f", 32'h00);     chk_rd(1, PIO_ADDR_EDGECAP);

        // Falling-edge instance
        @(negedge clk);
        in_port = 8'h00; settle();
        wr(PIO_ADDR_EDGECAP, 32'hFF);
        in_port = 8'h80; settle();
        push("t4_rise_f", 32'h00);   chk_rd(1, PIO_ADDR_EDGECAP);
        push("t4_rise_r", 32'h80);   chk_rd(0, PIO_ADDR_EDGECAP);
        @(negedge clk);
        in_port = 8'h00; settle();
        push("t4_fall_f", 32'h80);   chk_rd(1, PIO_ADDR_EDGECAP);
        push("t4_fall_r", 32'h80);   chk_rd(0, PIO_ADDR_EDGECAP);

        // Any-edge instance, double capture, data register read-only
        @(negedge clk);
        wr(PIO_ADDR_EDGECAP, 32'hFF);
        in_port = 8'h08; settle();
        push("t5_up_a", 32'h08);     chk_rd(2, PIO_ADDR_EDGECAP);
        @(negedge clk);
        wr(PIO_ADDR_EDGECAP, 32'h08);
        push("t5_clr_a", 32'h00);    chk_rd(2, PIO_ADDR_EDGECAP);
        @(negedge clk);
        in_port = 8'h00; settle();
        push("t5_down_a", 32'h08);   chk_rd(2, PIO_ADDR_EDGECAP);
        @(negedge clk);
        wr(PIO_ADDR_DATA, 32'hAA);
        wr(PIO_ADDR_DIR, 32'hFF);
        push("t5_data_ro", 32'h00);  chk_rd(2, PIO_ADDR_DATA);
        push("t5_dir_ro", 32'h00);   chk_rd(2, PIO_ADDR_DIR);

        // Mask gating, then asynchronous reset mid-cycle
        @(negedge clk);
        wr(PIO_ADDR_EDGECAP, 32'hFF);
        wr(PIO_ADDR_IRQMASK, 32'h10);
        in_port = 8'h10; settle();
        push("t6_edge_r", 32'h10);   chk_rd(0, PIO_ADDR_EDGECAP);
        push("t6_irq_r", 32'h1);     chk_irq(0);
        @(negedge clk);
        wr(PIO_ADDR_IRQMASK, 32'h00);
        push("t6_unmask_irq", 32'h0); chk_irq(0);
        push("t6_keep_edge", 32'h10); chk_rd(0, PIO_ADDR_EDGECAP);
        @(negedge clk);
        wr(PIO_ADDR_IRQMASK, 32'h10);
        push("t6_remask_irq", 32'h1); chk_irq(0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        push("t6_rst_irq", 32'h0);   chk_irq(0);
        push("t6_rst_mask", 32'h0);  chk_rd(0, PIO_ADDR_IRQMASK);
        push("t6_rst_edge", 32'h0);  chk_rd(0, PIO_ADDR_EDGECAP);
        push("t6_rst_data", 32'h0);  chk_rd(0, PIO_ADDR_DATA);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        push("t6_rearm_edge", 32'h0); chk_rd(0, PIO_ADDR_EDGECAP);
        push("t6_rearm_data", 32'h10); chk_rd(0, PIO_ADDR_DATA);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed %0d expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
